// File: rtl/apu_wb_queue_if.sv
// Bus bundle between the APU result outputs, apu_wb_queue and the register file APU write port.
// master = the queue's view (accepts results, drives writes); slave = the surrounding environment.
interface apu_wb_queue_if #(
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5
);
    logic                     res_valid;
    logic                     res_ready;
    logic [reg_sel_width-1:0] res_sel;
    logic [data_width-1:0]    res_data;
    logic                     apu_wr_req;
    logic                     apu_ack;
    logic [reg_sel_width-1:0] apu_wr_sel;
    logic [data_width-1:0]    apu_wr_data;

    modport master (
        input  res_valid, res_sel, res_data, apu_ack,
        output res_ready, apu_wr_req, apu_wr_sel, apu_wr_data
    );

    modport slave (
        output res_valid, res_sel, res_data, apu_ack,
        input  res_ready, apu_wr_req, apu_wr_sel, apu_wr_data
    );
endinterface

// File: rtl/apu_wb_queue.sv
// In-order write-back FIFO from the APU units to the register file APU write port.
// Optional macro APU_WB_PENDING_EN adds pend_mask, the set of registers with queued writes.
module apu_wb_queue #(
    parameter int data_width    = 32,
    parameter int reg_sel_width = 5,
    parameter int depth         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    apu_wb_queue_if.master        q_if,
    output logic                  busy
`ifdef APU_WB_PENDING_EN
    ,
    output logic [2**reg_sel_width-1:0] pend_mask
`endif
);
    localparam int ptr_w = $clog2(depth);
    localparam logic [ptr_w:0] full_cnt = (ptr_w+1)'(depth);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [ptr_w-1:0]         wr_ptr_q, wr_ptr_d;
    logic [ptr_w-1:0]         rd_ptr_q, rd_ptr_d;
    logic [ptr_w:0]           count_q, count_d;
    logic [reg_sel_width-1:0] sel_mem_q  [depth];
    logic [reg_sel_width-1:0] sel_mem_d  [depth];
    logic [data_width-1:0]    data_mem_q [depth];
    logic [data_width-1:0]    data_mem_d [depth];
    logic                     wr_req_q, wr_req_d;
    logic [reg_sel_width-1:0] wr_sel_q, wr_sel_d;
    logic [data_width-1:0]    wr_data_q, wr_data_d;
    logic                     res_ready;
    logic                     push;
    logic                     pop;

    assign res_ready        = (count_q != full_cnt);
    assign q_if.res_ready   = res_ready;
    assign q_if.apu_wr_req  = wr_req_q;
    assign q_if.apu_wr_sel  = wr_sel_q;
    assign q_if.apu_wr_data = wr_data_q;
    assign busy             = (count_q != '0) || (state_q != S_IDLE);

    // Writes to x0 complete the handshake but are never stored.
    assign push = q_if.res_valid && res_ready && (q_if.res_sel != '0);
    assign pop  = (state_q == S_WAIT) && q_if.apu_ack;

    always_comb begin
        sel_mem_d  = sel_mem_q;
        data_mem_d = data_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            sel_mem_d[wr_ptr_q]  = q_if.res_sel;
            data_mem_d[wr_ptr_q] = q_if.res_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The head stays in the FIFO until acked so it remains visible to pend_mask.
    always_comb begin
        state_d   = state_q;
        wr_req_d  = wr_req_q;
        wr_sel_d  = wr_sel_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    wr_req_d  = 1'b1;
                    wr_sel_d  = sel_mem_q[rd_ptr_q];
                    wr_data_d = data_mem_q[rd_ptr_q];
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                wr_req_d = 1'b0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (q_if.apu_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                wr_req_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            wr_req_q  <= 1'b0;
            wr_sel_q  <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < depth; i++) begin
                sel_mem_q[i]  <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wr_req_q   <= wr_req_d;
            wr_sel_q   <= wr_sel_d;
            wr_data_q  <= wr_data_d;
            sel_mem_q  <= sel_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

`ifdef APU_WB_PENDING_EN
    logic [ptr_w-1:0] offs;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        pend_mask = '0;
        offs      = '0;
        for (int i = 0; i < depth; i++) begin
            offs = ptr_w'(i) - rd_ptr_q;
            if ({1'b0, offs} < count_q) begin
                pend_mask[sel_mem_q[i]] = 1'b1;
            end
        end
        pend_mask[0] = 1'b0;
    end
`endif
endmodule

// File: tb/tb_apu_wb_queue.sv
// Directed self-checking bench for apu_wb_queue (pend_mask checks when APU_WB_PENDING_EN is defined).
module tb_apu_wb_queue;
    logic        clk;
    logic        rst;
    logic        busy;
`ifdef APU_WB_PENDING_EN
    logic [31:0] pend_mask;
`endif
    int          n_cmp;
    int          n_err;

    apu_wb_queue_if #(.data_width(32), .reg_sel_width(5)) q_if ();

    apu_wb_queue #(.data_width(32), .reg_sel_width(5), .depth(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .q_if      (q_if.master),
        .busy      (busy)
`ifdef APU_WB_PENDING_EN
        ,
        .pend_mask (pend_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("[TB] check %s", tag);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [4:0] sel, input logic [31:0] data);
        q_if.res_valid = valid;
        q_if.res_sel   = sel;
        q_if.res_data  = data;
    endtask

    logic [4:0]  exp_sel [4];
    logic [31:0] exp_data [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b0;
        q_if.apu_ack = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0);
        #2;
        checkOutput("rst_req", q_if.apu_wr_req, 0);
        checkOutput("rst_sel", q_if.apu_wr_sel, 0);
        checkOutput("rst_data", q_if.apu_wr_data, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", q_if.res_ready, 1);
`ifdef APU_WB_PENDING_EN
        checkOutput("rst_pend", pend_mask, 0);
`endif
        tick();
        tick();
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("idle_req", q_if.apu_wr_req, 0);
            checkOutput("idle_busy", busy, 0);
        end

        // Single write: push at edge N, req in the following cycle, ack in WAIT.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        checkOutput("single_n_req", q_if.apu_wr_req, 0);
        checkOutput("single_n_busy", busy, 1);
        tick();
        checkOutput("single_req", q_if.apu_wr_req, 1);
        checkOutput("single_sel", q_if.apu_wr_sel, 5);
        checkOutput("single_data", q_if.apu_wr_data, 32'hDEADBEEF);
        tick();
        checkOutput("single_req_drop", q_if.apu_wr_req, 0);
        checkOutput("single_sel_hold", q_if.apu_wr_sel, 5);
        checkOutput("single_busy_wait", busy, 1);
`ifdef APU_WB_PENDING_EN
        checkOutput("single_pend", pend_mask, 32'h20);
`endif
        q_if.apu_ack = 1'b1;
        tick();
        q_if.apu_ack = 1'b0;
        checkOutput("single_busy_done", busy, 0);
        checkOutput("single_req_done", q_if.apu_wr_req, 0);

        // x0 writes are accepted and dropped.
        applyStimulus(1'b1, 5'd0, 32'h1234);
        checkOutput("x0_ready", q_if.res_ready, 1);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("x0_req", q_if.apu_wr_req, 0);
            checkOutput("x0_busy", busy, 0);
            tick();
        end

        // Fill four entries while the register file withholds ack.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 5'(i), 32'h100 + 32'(i));
            checkOutput("fill_ready", q_if.res_ready, 1);
            tick();
            checkOutput("fill_req", q_if.apu_wr_req, (i == 2) ? 1 : 0);
            if (i == 2) begin
                checkOutput("fill_sel1", q_if.apu_wr_sel, 1);
                checkOutput("fill_data1", q_if.apu_wr_data, 32'h101);
            end
        end
        applyStimulus(1'b1, 5'd6, 32'h106);
        checkOutput("full_ready", q_if.res_ready, 0);
`ifdef APU_WB_PENDING_EN
        checkOutput("full_pend", pend_mask, 32'h1E);
`endif
        tick();
        checkOutput("full_ready_hold", q_if.res_ready, 0);
        q_if.apu_ack = 1'b1;
        tick();
        checkOutput("pop_ready", q_if.res_ready, 1);
        checkOutput("pop_req", q_if.apu_wr_req, 0);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        exp_sel[0] = 5'd2; exp_data[0] = 32'h102;
        exp_sel[1] = 5'd3; exp_data[1] = 32'h103;
        exp_sel[2] = 5'd4; exp_data[2] = 32'h104;
        exp_sel[3] = 5'd6; exp_data[3] = 32'h106;
        for (int k = 0; k < 4; k++) begin
            checkOutput("drain_req", q_if.apu_wr_req, 1);
            checkOutput("drain_sel", q_if.apu_wr_sel, exp_sel[k]);
            checkOutput("drain_data", q_if.apu_wr_data, exp_data[k]);
            tick();
            checkOutput("drain_req_r", q_if.apu_wr_req, 0);
            tick();
            checkOutput("drain_req_w", q_if.apu_wr_req, 0);
            tick();
        end
        checkOutput("drain_busy", busy, 0);
        q_if.apu_ack = 1'b0;

        // Slow ack, with ack already high in IDLE and REQ, where it must be ignored.
        applyStimulus(1'b1, 5'd10, 32'hA5A5A5A5);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        q_if.apu_ack = 1'b1;
        tick();
        checkOutput("slow_req", q_if.apu_wr_req, 1);
        checkOutput("slow_sel", q_if.apu_wr_sel, 10);
        tick();
        q_if.apu_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("slow_wait_req", q_if.apu_wr_req, 0);
            checkOutput("slow_wait_sel", q_if.apu_wr_sel, 10);
            checkOutput("slow_wait_data", q_if.apu_wr_data, 32'hA5A5A5A5);
            checkOutput("slow_wait_busy", busy, 1);
            tick();
        end
        q_if.apu_ack = 1'b1;
        tick();
        q_if.apu_ack = 1'b0;
        checkOutput("slow_done_busy", busy, 0);
        checkOutput("slow_done_req", q_if.apu_wr_req, 0);

        // Reset while a write waits for ack; a later ack must do nothing.
        applyStimulus(1'b1, 5'd7, 32'h7);
        tick();
        applyStimulus(1'b1, 5'd9, 32'h9);
        tick();
        applyStimulus(1'b0, 5'd0, 32'h0);
        checkOutput("mid_req", q_if.apu_wr_req, 1);
`ifdef APU_WB_PENDING_EN
        checkOutput("mid_pend", pend_mask, 32'h280);
`endif
        tick();
        checkOutput("mid_wait_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_req", q_if.apu_wr_req, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_sel", q_if.apu_wr_sel, 0);
`ifdef APU_WB_PENDING_EN
        checkOutput("mid_rst_pend", pend_mask, 0);
`endif
        tick();
        rst = 1'b1;
        q_if.apu_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("post_rst_req", q_if.apu_wr_req, 0);
            checkOutput("post_rst_busy", busy, 0);
        end
        q_if.apu_ack = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
